cps_asram_sched: RTL and testbench

- Slot scheduler and CPU request sequencer for the shared VRAM async-SRAM controller.
- Generates the 4-phase cycle strobes (ram_cyc), the 4-slot access pattern (ram_acc: slots 0,2 = CPU; slots 1,3 = GPU) and periodic refresh frames (ram_ref).
- Converts the 68000-side level req/ack handshake into slot-aligned CPU read/write requests.
- Sits between the 68000 bus glue and the SRAM controller; the GPU side connects to the controller directly.

---
 rtl/cps_asram_sched_if.sv | 28 ++
 rtl/cps_asram_sched.sv | 163 ++++++++++++++++
 tb/tb_cps_asram_sched.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cps_asram_sched_if.sv
// Host request/ack handshake plus CPU-side request bus to the async-SRAM controller.
// slave = scheduler view; master = the 68000 glue and SRAM controller together.
interface cps_asram_sched_if;
  logic        host_req;
  logic        host_we;
  logic [1:0]  host_bena;
  logic [19:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic        cpu_rden;
  logic        cpu_wren;
  logic [1:0]  cpu_bena;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_valid;

  modport slave (
    input  host_req, host_we, host_bena, host_addr, host_wdata, cpu_rdata, cpu_valid,
    output host_rdata, host_ack, cpu_rden, cpu_wren, cpu_bena, cpu_addr, cpu_wdata
  );

  modport master (
    output host_req, host_we, host_bena, host_addr, host_wdata, cpu_rdata, cpu_valid,
    input  host_rdata, host_ack, cpu_rden, cpu_wren, cpu_bena, cpu_addr, cpu_wdata
  );
endinterface

// File: rtl/cps_asram_sched.sv
// VRAM slot scheduler: 4-phase cycle strobes, CPU/GPU slot pattern, refresh frames, CPU sequencing.
// Host ack 4..28 clocks after request acceptance; host_req is held by the host until ack.
module cps_asram_sched #(
  parameter int REF_INTERVAL = 64
) (
  input  logic             bus_clk,
  input  logic             bus_rst,
  input  logic             ref_en,
  cps_asram_sched_if.slave bus,
  output logic             ram_ref,
  output logic [3:0]       ram_cyc,
  output logic [3:0]       ram_acc
);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUED, DONE} state_t;

  localparam logic [11:0] REF_LAST = 12'(REF_INTERVAL - 1);

  state_t      state_q, state_d;
  logic [1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [1:0]  acc_cnt_q, acc_cnt_d;
  logic [11:0] ref_cnt_q, ref_cnt_d;
  logic        ram_ref_q, ram_ref_d;
  logic [3:0]  ram_cyc_q, ram_cyc_d;
  logic [3:0]  ram_acc_q, ram_acc_d;
  logic        cpu_rden_q, cpu_rden_d;
  logic        cpu_wren_q, cpu_wren_d;
  logic [1:0]  cpu_bena_q, cpu_bena_d;
  logic [19:0] cpu_addr_q, cpu_addr_d;
  logic [15:0] cpu_wdata_q, cpu_wdata_d;
  logic [15:0] host_rdata_q, host_rdata_d;
  logic        host_ack_q, host_ack_d;
  logic        frame_end;
  logic        cpu_slot;

  function automatic logic [3:0] onehot(input logic [1:0] v);
    onehot = 4'b0001 << v;
  endfunction

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 2'd1;
    acc_cnt_d = acc_cnt_q;
    if (cyc_cnt_q == 2'd3) begin
      acc_cnt_d = acc_cnt_q + 2'd1;
    end
    frame_end = (cyc_cnt_q == 2'd3) && (acc_cnt_q == 2'd3);

    ram_ref_d = ram_ref_q;
    ref_cnt_d = ref_en ? ref_cnt_q : 12'd0;
    if (frame_end) begin
      if (ram_ref_q) begin
        ram_ref_d = 1'b0;
      end else if (ref_en && (ref_cnt_q == REF_LAST)) begin
        ram_ref_d = 1'b1;
        ref_cnt_d = 12'd0;
      end else if (ref_en) begin
        ref_cnt_d = ref_cnt_q + 12'd1;
      end
    end

    // Strobes are registered copies of the next counter values so they line up with the counters.
    ram_cyc_d = onehot(cyc_cnt_d);
    ram_acc_d = ram_ref_d ? 4'b0000 : onehot(acc_cnt_d);
  end

  assign cpu_slot = (ram_acc_q[0] | ram_acc_q[2]) & ~ram_ref_q;

  always_comb begin
    state_d      = state_q;
    cpu_rden_d   = cpu_rden_q;
    cpu_wren_d   = cpu_wren_q;
    cpu_bena_d   = cpu_bena_q;
    cpu_addr_d   = cpu_addr_q;
    cpu_wdata_d  = cpu_wdata_q;
    host_rdata_d = host_rdata_q;
    host_ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.host_req) begin
          cpu_addr_d  = bus.host_addr;
          cpu_bena_d  = bus.host_bena;
          cpu_wdata_d = bus.host_wdata;
          cpu_wren_d  = bus.host_we;
          cpu_rden_d  = ~bus.host_we;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // The controller samples the request on the edge that ends cyc[0] of a CPU slot.
        if (ram_cyc_q[0] && cpu_slot) begin
          state_d = ISSUED;
        end
      end
      ISSUED: begin
        if (cpu_wren_q) begin
          if (ram_cyc_q[3]) begin
            host_ack_d = 1'b1;
            cpu_wren_d = 1'b0;
            state_d    = DONE;
          end
        end else if (bus.cpu_valid) begin
          host_rdata_d = bus.cpu_rdata;
          host_ack_d   = 1'b1;
          cpu_rden_d   = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (!bus.host_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      state_q      <= IDLE;
      cyc_cnt_q    <= 2'd0;
      acc_cnt_q    <= 2'd0;
      ref_cnt_q    <= 12'd0;
      ram_ref_q    <= 1'b0;
      ram_cyc_q    <= 4'b0001;
      ram_acc_q    <= 4'b0001;
      cpu_rden_q   <= 1'b0;
      cpu_wren_q   <= 1'b0;
      cpu_bena_q   <= 2'd0;
      cpu_addr_q   <= 20'd0;
      cpu_wdata_q  <= 16'd0;
      host_rdata_q <= 16'd0;
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      acc_cnt_q    <= acc_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      ram_ref_q    <= ram_ref_d;
      ram_cyc_q    <= ram_cyc_d;
      ram_acc_q    <= ram_acc_d;
      cpu_rden_q   <= cpu_rden_d;
      cpu_wren_q   <= cpu_wren_d;
      cpu_bena_q   <= cpu_bena_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_wdata_q  <= cpu_wdata_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign ram_ref        = ram_ref_q;
  assign ram_cyc        = ram_cyc_q;
  assign ram_acc        = ram_acc_q;
  assign bus.cpu_rden   = cpu_rden_q;
  assign bus.cpu_wren   = cpu_wren_q;
  assign bus.cpu_bena   = cpu_bena_q;
  assign bus.cpu_addr   = cpu_addr_q;
  assign bus.cpu_wdata  = cpu_wdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.host_ack   = host_ack_q;

endmodule

// File: tb/tb_cps_asram_sched.sv
// Directed bench for cps_asram_sched with a small SRAM-controller model answering CPU reads.
module tb_cps_asram_sched;

  logic       bus_clk = 1'b0;
  logic       bus_rst;
  logic       ref_en;
  logic       ram_ref;
  logic [3:0] ram_cyc;
  logic [3:0] ram_acc;

  cps_asram_sched_if bus ();

  cps_asram_sched #(.REF_INTERVAL(2)) dut (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .ref_en  (ref_en),
    .bus     (bus),
    .ram_ref (ram_ref),
    .ram_cyc (ram_cyc),
    .ram_acc (ram_acc)
  );

  always #5 bus_clk = ~bus_clk;

  int   n_cmp    = 0;
  int   n_err    = 0;
  int   n_access = 0;
  int   cyc      = 0;
  int   acks     = 0;
  logic rd_pend  = 1'b0;
  logic tb_slot;

  assign tb_slot = (ram_acc[0] | ram_acc[2]) & ~ram_ref;

  // Controller model: counts sampled requests; read data returns in the cycle after cyc[3].
  always @(negedge bus_clk) begin
    if (bus_rst) begin
      rd_pend       = 1'b0;
      bus.cpu_valid = 1'b0;
      bus.cpu_rdata = 16'h0000;
    end else begin
      bus.cpu_valid = 1'b0;
      if (rd_pend && ram_cyc[0]) begin
        bus.cpu_valid = 1'b1;
        bus.cpu_rdata = 16'h1234;
        rd_pend       = 1'b0;
      end else if (ram_cyc[0] && tb_slot && (bus.cpu_wren || bus.cpu_rden)) begin
        n_access++;
        rd_pend = bus.cpu_rden;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge bus_clk);
    #2;
    cyc++;
  endtask

  task automatic goto_cyc(input int k);
    while (cyc < k) step();
  endtask

  task automatic drive_req(input logic we, input logic [19:0] a, input logic [1:0] be,
                           input logic [15:0] wd);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = a;
    bus.host_bena  = be;
    bus.host_wdata = wd;
  endtask

  logic [3:0] exp_c;
  logic [3:0] exp_a;

  initial begin
    bus_rst        = 1'b1;
    ref_en         = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_bena  = 2'b00;
    bus.host_addr  = 20'h0;
    bus.host_wdata = 16'h0;

    // Reset state
    repeat (3) @(posedge bus_clk);
    #2;
    check("rst_ram_cyc",    32'(ram_cyc), 32'h1);
    check("rst_ram_acc",    32'(ram_acc), 32'h1);
    check("rst_ram_ref",    32'(ram_ref), 32'h0);
    check("rst_host_ack",   32'(bus.host_ack), 32'h0);
    check("rst_host_rdata", 32'(bus.host_rdata), 32'h0);
    check("rst_cpu_wren",   32'(bus.cpu_wren), 32'h0);
    check("rst_cpu_rden",   32'(bus.cpu_rden), 32'h0);
    check("rst_cpu_addr",   32'(bus.cpu_addr), 32'h0);
    bus_rst = 1'b0;
    cyc     = 0;

    // Phase and slot sequence after reset release
    for (int i = 1; i <= 16; i++) begin
      step();
      exp_c = 4'b0001 << (i % 4);
      exp_a = 4'b0001 << ((i / 4) % 4);
      check("seq_ram_cyc", 32'(ram_cyc), 32'(exp_c));
      check("seq_ram_acc", 32'(ram_acc), 32'(exp_a));
      check("seq_ram_ref", 32'(ram_ref), 32'h0);
    end

    // Write requested in GPU slot 1, served in CPU slot 2
    goto_cyc(20);
    drive_req(1'b1, 20'h00012, 2'b11, 16'hBEEF);
    step();
    check("wr_cpu_wren",  32'(bus.cpu_wren), 32'h1);
    check("wr_cpu_rden",  32'(bus.cpu_rden), 32'h0);
    check("wr_cpu_addr",  32'(bus.cpu_addr), 32'h00012);
    check("wr_cpu_bena",  32'(bus.cpu_bena), 32'h3);
    check("wr_cpu_wdata", 32'(bus.cpu_wdata), 32'hBEEF);
    goto_cyc(27);
    check("wr_cyc3_slot2", 32'({ram_acc, ram_cyc}), 32'h48);
    check("wr_ack_early",  32'(bus.host_ack), 32'h0);
    check("wr_wren_held",  32'(bus.cpu_wren), 32'h1);
    step();
    check("wr_ack",        32'(bus.host_ack), 32'h1);
    check("wr_wren_clr",   32'(bus.cpu_wren), 32'h0);
    check("wr_n_access",   32'(n_access), 32'd1);
    bus.host_req = 1'b0;
    step();
    check("wr_ack_pulse",  32'(bus.host_ack), 32'h0);

    // Read served in slot 0 of the next frame, data back in slot 1 cyc[0]
    drive_req(1'b0, 20'h00010, 2'b11, 16'h0000);
    step();
    check("rd_cpu_rden",   32'(bus.cpu_rden), 32'h1);
    check("rd_cpu_wren",   32'(bus.cpu_wren), 32'h0);
    check("rd_cpu_addr",   32'(bus.cpu_addr), 32'h00010);
    goto_cyc(36);
    check("rd_ack_early",  32'(bus.host_ack), 32'h0);
    check("rd_rden_held",  32'(bus.cpu_rden), 32'h1);
    step();
    check("rd_ack",        32'(bus.host_ack), 32'h1);
    check("rd_rdata",      32'(bus.host_rdata), 32'h1234);
    check("rd_rden_clr",   32'(bus.cpu_rden), 32'h0);
    bus.host_req = 1'b0;
    step();
    check("rd_ack_pulse",  32'(bus.host_ack), 32'h0);
    check("rd_rdata_hold", 32'(bus.host_rdata), 32'h1234);
    check("rd_n_access",   32'(n_access), 32'd2);

    // Held request: exactly one access and one ack
    drive_req(1'b1, 20'h0ABCD, 2'b01, 16'h5A5A);
    acks = 0;
    while (cyc < 70) begin
      step();
      if (bus.host_ack) acks++;
    end
    check("hold_acks",     32'(acks), 32'd1);
    check("hold_n_access", 32'(n_access), 32'd3);
    check("hold_wren",     32'(bus.cpu_wren), 32'h0);
    check("hold_addr",     32'(bus.cpu_addr), 32'h0ABCD);
    check("hold_bena",     32'(bus.cpu_bena), 32'h1);
    bus.host_req = 1'b0;

    // Re-raised request: latched in cyc[0] of slot 2, so waits for slot 0 of next frame
    goto_cyc(72);
    drive_req(1'b1, 20'h00100, 2'b10, 16'h0F0F);
    goto_cyc(83);
    check("rr_ack_early",  32'(bus.host_ack), 32'h0);
    check("rr_wren",       32'(bus.cpu_wren), 32'h1);
    check("rr_wdata",      32'(bus.cpu_wdata), 32'h0F0F);
    step();
    check("rr_ack",        32'(bus.host_ack), 32'h1);
    check("rr_n_access",   32'(n_access), 32'd4);
    bus.host_req = 1'b0;

    // Refresh every third frame with REF_INTERVAL=2
    goto_cyc(96);
    ref_en = 1'b1;
    goto_cyc(127);
    check("ref_pre_ref",   32'(ram_ref), 32'h0);
    check("ref_pre_acc",   32'(ram_acc), 32'h8);
    step();
    check("ref_start_ref", 32'(ram_ref), 32'h1);
    check("ref_start_acc", 32'(ram_acc), 32'h0);
    check("ref_start_cyc", 32'(ram_cyc), 32'h1);
    drive_req(1'b1, 20'h00200, 2'b11, 16'h1111);
    goto_cyc(135);
    check("ref_mid_ref",   32'(ram_ref), 32'h1);
    check("ref_mid_acc",   32'(ram_acc), 32'h0);
    check("ref_mid_cyc",   32'(ram_cyc), 32'h8);
    check("ref_mid_wren",  32'(bus.cpu_wren), 32'h1);
    check("ref_mid_ack",   32'(bus.host_ack), 32'h0);
    goto_cyc(143);
    check("ref_end_ref",   32'(ram_ref), 32'h1);
    step();
    check("ref_post_ref",  32'(ram_ref), 32'h0);
    check("ref_post_acc",  32'(ram_acc), 32'h1);
    goto_cyc(147);
    check("ref_ack_early", 32'(bus.host_ack), 32'h0);
    step();
    check("ref_ack",       32'(bus.host_ack), 32'h1);
    check("ref_n_access",  32'(n_access), 32'd5);
    bus.host_req = 1'b0;

    // Reset while a read is ISSUED
    goto_cyc(150);
    drive_req(1'b0, 20'h00300, 2'b11, 16'h0000);
    goto_cyc(153);
    check("rst_rd_rden",   32'(bus.cpu_rden), 32'h1);
    check("rst_rd_cyc",    32'(ram_cyc), 32'h2);
    step();
    bus_rst = 1'b1;
    #1;
    check("arst_rden",     32'(bus.cpu_rden), 32'h0);
    check("arst_cyc",      32'(ram_cyc), 32'h1);
    check("arst_acc",      32'(ram_acc), 32'h1);
    check("arst_ack",      32'(bus.host_ack), 32'h0);
    bus.host_req = 1'b0;
    acks = 0;
    repeat (3) begin
      step();
      if (bus.host_ack) acks++;
    end
    bus_rst = 1'b0;
    cyc     = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.host_ack) acks++;
    end
    check("arst_no_ack",   32'(acks), 32'd0);
    check("arst_n_access", 32'(n_access), 32'd6);
    check("arst_post_cyc", 32'(ram_cyc), 32'h1);
    check("arst_post_acc", 32'(ram_acc), 32'h4);
    check("arst_post_ref", 32'(ram_ref), 32'h0);
    check("arst_post_rd",  32'(bus.cpu_rden), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
